// File: rtl/dip_pkg.sv
// Shared types and defaults for the DIP-switch reader and the PSCLK divider.
package dip_pkg;

    localparam int DIP_WIDTH_DEF   = 8;
    localparam int DIP_CLK_DIV_DEF = 25;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } dip_state_t;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ps_tick_gen.sv
// Half-period divider for the shared peripheral shift clock; tick marks the
// last cycle of each CLK_DIV-cycle half period.
module ps_tick_gen
    import dip_pkg::*;
#(
    parameter int CLK_DIV = DIP_CLK_DIV_DEF
) (
    input  logic i_CLK,
    input  logic i_SYS_RESET,
    input  logic i_Clr,
    output logic o_Tick
);

    localparam int              CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0]   TC = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_CLK or posedge i_SYS_RESET) begin
        if (i_SYS_RESET) begin
            r_cnt <= '0;
        end else if (i_Clr || (r_cnt == TC)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_Tick = (r_cnt == TC);

endmodule

// File: rtl/dip_reader.sv
// Serial reader for the DIP-switch shift register: latch, shift in WIDTH bits
// MSB first on PSCLK, then present the word with a one-cycle valid strobe.
//
// state | meaning
// IDLE  | waiting for i_Start or i_Auto; divider held clear
// LATCH | o_DIPLatch high for two half periods
// SHIFT | PSCLK low half (sample at its end), then high half, per bit
// DONE  | o_Data updated, o_Valid high for one cycle
module dip_reader
    import dip_pkg::*;
#(
    parameter int WIDTH   = DIP_WIDTH_DEF,
    parameter int CLK_DIV = DIP_CLK_DIV_DEF,
    parameter bit INVERT  = 1'b0
) (
    input  logic             i_CLK,
    input  logic             i_SYS_RESET,
    input  logic             i_Start,
    input  logic             i_Auto,
    output logic             o_PSCLK,
    output logic             o_DIPLatch,
    input  logic             i_DIPData,
    output logic [WIDTH-1:0] o_Data,
    output logic             o_Valid,
    output logic             o_Busy
);

    localparam int            BW       = cnt_width(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    dip_state_t       r_state;
    logic             r_phase;
    logic [BW-1:0]    r_bit;
    logic [WIDTH-1:0] r_shift;
    logic             r_psclk;
    logic             r_latch;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_busy;

    dip_state_t       w_state_nxt;
    logic             w_phase_nxt;
    logic [BW-1:0]    w_bit_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             w_psclk_nxt;
    logic             w_latch_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_valid_nxt;
    logic             w_busy_nxt;
    logic             w_tick;
    logic             w_div_clr;

    assign w_div_clr = (r_state == ST_IDLE);

    ps_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_CLK       (i_CLK),
        .i_SYS_RESET (i_SYS_RESET),
        .i_Clr       (w_div_clr),
        .o_Tick      (w_tick)
    );

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge i_CLK or posedge i_SYS_RESET) begin
        if (i_SYS_RESET) begin
            r_state <= ST_IDLE;
            r_phase <= 1'b0;
            r_bit   <= '0;
            r_shift <= '0;
            r_psclk <= 1'b0;
            r_latch <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_psclk <= w_psclk_nxt;
            r_latch <= w_latch_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        case (r_state)
            ST_IDLE: begin
                w_phase_nxt = 1'b0;
                if (i_Start || i_Auto) begin
                    w_state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (w_tick) begin
                    if (r_phase) begin
                        w_state_nxt = ST_SHIFT;
                        w_phase_nxt = 1'b0;
                        w_bit_nxt   = BIT_LAST;
                    end else begin
                        w_phase_nxt = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    if (!r_phase) begin
                        w_shift_nxt = (r_shift << 1) | WIDTH'(i_DIPData);
                        w_phase_nxt = 1'b1;
                    end else if (r_bit == '0) begin
                        w_state_nxt = ST_DONE;
                        w_phase_nxt = 1'b0;
                    end else begin
                        w_bit_nxt   = r_bit - BW'(1);
                        w_phase_nxt = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_psclk_nxt = (w_state_nxt == ST_SHIFT) && w_phase_nxt;
        w_latch_nxt = (w_state_nxt == ST_LATCH);
        w_valid_nxt = (w_state_nxt == ST_DONE);
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
        w_data_nxt  = r_data;
        if (w_state_nxt == ST_DONE) begin
            w_data_nxt = INVERT ? ~r_shift : r_shift;
        end
    end

    assign o_PSCLK    = r_psclk;
    assign o_DIPLatch = r_latch;
    assign o_Data     = r_data;
    assign o_Valid    = r_valid;
    assign o_Busy     = r_busy;

endmodule

// File: tb/tb_dip_reader.sv
// Bench for dip_reader with W=8, D=2: a 74HC165-style model per instance,
// a table of single reads, then busy-start, mid-read reset and auto mode.
module tb_dip_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       auto_m = 1'b0;
    logic [7:0] pat = 8'h00;

    logic       ps0, lat0, v0, busy0, sd0;
    logic       ps1, lat1, v1, busy1, sd1;
    logic [7:0] d0, d1;

    always #5 clk = ~clk;

    dip_reader #(.WIDTH(8), .CLK_DIV(2), .INVERT(1'b0)) u_dut0 (
        .i_CLK(clk), .i_SYS_RESET(rst), .i_Start(start), .i_Auto(auto_m),
        .o_PSCLK(ps0), .o_DIPLatch(lat0), .i_DIPData(sd0),
        .o_Data(d0), .o_Valid(v0), .o_Busy(busy0));

    dip_reader #(.WIDTH(8), .CLK_DIV(2), .INVERT(1'b1)) u_dut1 (
        .i_CLK(clk), .i_SYS_RESET(rst), .i_Start(start), .i_Auto(auto_m),
        .o_PSCLK(ps1), .o_DIPLatch(lat1), .i_DIPData(sd1),
        .o_Data(d1), .o_Valid(v1), .o_Busy(busy1));

    // External shift register model: parallel load while latch high, shift on PSCLK rise.
    logic [7:0] sr0 = 8'h00, sr1 = 8'h00;
    logic       ps0_q = 1'b0, ps1_q = 1'b0;
    always @(posedge clk) begin
        if (lat0) sr0 <= pat;
        else if (ps0 && !ps0_q) sr0 <= sr0 << 1;
        if (lat1) sr1 <= pat;
        else if (ps1 && !ps1_q) sr1 <= sr1 << 1;
        ps0_q <= ps0;
        ps1_q <= ps1;
    end
    assign sd0 = sr0[7];
    assign sd1 = sr1[7];

    // Monitor, sampled mid-cycle.
    int         cyc = 0;
    int         nv = 0, nv1 = 0;
    int         vcyc [16];
    logic [7:0] vdat0 [16];
    logic [7:0] vdat1 [16];
    int         lat_rises = 0, lat_hi = 0, lat_rise_cyc = 0, ps_rises = 0;
    logic       lat_prev = 1'b0, ps_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (v0 && nv < 16) begin
            vcyc[nv]  = cyc;
            vdat0[nv] = d0;
            nv++;
        end
        if (v1 && nv1 < 16) begin
            vdat1[nv1] = d1;
            nv1++;
        end
        if (lat0 && !lat_prev) begin
            lat_rises++;
            lat_rise_cyc = cyc;
        end
        if (lat0) lat_hi++;
        if (ps0 && !ps_prev) ps_rises++;
        lat_prev = lat0;
        ps_prev  = ps0;
    end

    int errors = 0;
    int checks = 0;
    int t0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc - t0 < c) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    typedef struct {
        logic [7:0] pat;
        logic [7:0] exp;
        logic [7:0] exp_inv;
    } vec_t;

    vec_t tbl [5];
    int   nv_s, nv1_s, lr_s, lh_s, pr_s;

    task automatic snap();
        nv_s  = nv;
        nv1_s = nv1;
        lr_s  = lat_rises;
        lh_s  = lat_hi;
        pr_s  = ps_rises;
        t0    = cyc;
    endtask

    initial begin
        tbl[0] = '{8'hA5, 8'hA5, 8'h5A};
        tbl[1] = '{8'h00, 8'h00, 8'hFF};
        tbl[2] = '{8'hFF, 8'hFF, 8'h00};
        tbl[3] = '{8'h81, 8'h81, 8'h7E};
        tbl[4] = '{8'h3C, 8'h3C, 8'hC3};

        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs0", {23'd0, ps0, lat0, d0}, 32'd0);
        chk("reset_flags0", {30'd0, v0, busy0}, 32'd0);
        chk("reset_outputs1", {23'd0, ps1, lat1, d1}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            pat = tbl[i].pat;
            snap();
            pulse_start();
            wait_to(38);
            chk("valid_count", 32'(nv - nv_s), 32'd1);
            chk("valid_cycle", 32'(vcyc[nv_s] - t0), 32'd37);
            chk("data", 32'(vdat0[nv_s]), 32'(tbl[i].exp));
            chk("data_inv", 32'(vdat1[nv1_s]), 32'(tbl[i].exp_inv));
            chk("latch_first_cycle", 32'(lat_rise_cyc - t0), 32'd1);
            chk("latch_high_cycles", 32'(lat_hi - lh_s), 32'd4);
            chk("psclk_rises", 32'(ps_rises - pr_s), 32'd8);
            chk("busy_after", 32'(busy0), 32'd0);
            chk("data_hold", 32'(d0), 32'(tbl[i].exp));
        end

        // Start while busy: second request at cycle 10 is dropped.
        pat = 8'hA5;
        snap();
        pulse_start();
        wait_to(10);
        pulse_start();
        wait_to(38);
        chk("busy_start_busy38", 32'(busy0), 32'd0);
        wait_to(50);
        chk("busy_start_valids", 32'(nv - nv_s), 32'd1);
        chk("busy_start_vcycle", 32'(vcyc[nv_s] - t0), 32'd37);
        chk("busy_start_latches", 32'(lat_rises - lr_s), 32'd1);
        chk("busy_start_data", 32'(d0), 32'hA5);

        // Reset mid-shift at cycle 20 aborts the read and clears o_Data.
        pat = 8'h81;
        snap();
        pulse_start();
        wait_to(20);
        rst = 1'b1;
        #1;
        chk("abort_psclk", 32'(ps0), 32'd0);
        chk("abort_latch", 32'(lat0), 32'd0);
        chk("abort_data", 32'(d0), 32'd0);
        chk("abort_busy", 32'(busy0), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        wait_to(45);
        chk("abort_no_valid", 32'(nv - nv_s), 32'd0);
        pat = 8'h3C;
        snap();
        pulse_start();
        wait_to(38);
        chk("after_abort_valid_cycle", 32'(vcyc[nv_s] - t0), 32'd37);
        chk("after_abort_data", 32'(vdat0[nv_s]), 32'h3C);

        // Auto mode: 3C then C3, auto dropped at cycle 50.
        pat = 8'h3C;
        snap();
        auto_m = 1'b1;
        wait_to(38);
        pat = 8'hC3;
        wait_to(50);
        auto_m = 1'b0;
        wait_to(120);
        chk("auto_valid_count", 32'(nv - nv_s), 32'd2);
        chk("auto_vcycle0", 32'(vcyc[nv_s] - t0), 32'd37);
        chk("auto_vcycle1", 32'(vcyc[nv_s + 1] - t0), 32'd75);
        chk("auto_data0", 32'(vdat0[nv_s]), 32'h3C);
        chk("auto_data1", 32'(vdat0[nv_s + 1]), 32'hC3);
        chk("auto_data_inv1", 32'(vdat1[nv1_s + 1]), 32'h3C);
        chk("auto_latches", 32'(lat_rises - lr_s), 32'd2);
        chk("auto_busy_end", 32'(busy0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
